// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and issue-side handshakes of the RV32I decode queue.
interface decode_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    logic                       in_valid;
    logic                       in_ready;
    logic [31:0]                in_inst;
    logic [PC_W-1:0]            in_pc;
    logic                       out_valid;
    logic                       out_ready;
    logic [PC_W-1:0]            out_pc;
    logic [2:0]                 out_type;
    logic [6:0]                 out_opcode;
    logic [2:0]                 out_funct3;
    logic [6:0]                 out_funct7;
    logic [4:0]                 out_rs1;
    logic [4:0]                 out_rs2;
    logic [4:0]                 out_rd;
    logic [31:0]                out_imm;
    logic                       out_illegal;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_type, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_illegal, count
    );
    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_type, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_illegal, count
    );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: RV32I decode-at-push FIFO between fetch and issue.
// Define DECODE_RV32M_EN to accept the RV32M funct7=0000001 R-type encodings.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decode_queue_if.slave q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [2:0]      typ;
        logic [6:0]      opc;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic            ill;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          ent_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop, shift, m_ok;
    logic [31:0]     inst;
    logic [6:0]      opc, f7;
    logic [2:0]      f3;

    assign inst  = q.in_inst;
    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign shift = opc == 7'b0010011 && f3[1:0] == 2'b01;
`ifdef DECODE_RV32M_EN
    assign m_ok  = f7 == 7'b0000001;
`else
    assign m_ok  = 1'b0;
`endif

    always_comb begin
        ent_d     = '0;
        ent_d.pc  = q.in_pc;
        ent_d.opc = opc;
        ent_d.f3  = f3;
        ent_d.f7  = f7;
        ent_d.rs1 = inst[19:15];
        ent_d.rs2 = inst[24:20];
        ent_d.rd  = inst[11:7];
        case (opc)
            7'b0110011: begin
                ent_d.typ = 3'd0;
                ent_d.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) || m_ok);
            end
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                ent_d.typ = 3'd1;
                ent_d.rs2 = '0;
                ent_d.f7  = shift ? f7 : 7'h00;
                ent_d.imm = {{20{inst[31]}}, inst[31:20]};
                ent_d.ill = shift && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b101));
            end
            7'b0100011: begin
                ent_d.typ = 3'd2;
                ent_d.rd  = '0;
                ent_d.f7  = '0;
                ent_d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                ent_d.typ = 3'd3;
                ent_d.rd  = '0;
                ent_d.f7  = '0;
                ent_d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b1101111, 7'b0110111, 7'b0010111: begin
                ent_d.typ = opc == 7'b1101111 ? 3'd4 : 3'd5;
                ent_d.rs1 = '0;
                ent_d.rs2 = '0;
                ent_d.f3  = '0;
                ent_d.f7  = '0;
                ent_d.imm = opc == 7'b1101111 ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
                                              : {inst[31:12], 12'b0};
            end
            default: begin
                ent_d     = '0;
                ent_d.pc  = q.in_pc;
                ent_d.ill = 1'b1;
            end
        endcase
    end

    // Flush wins over both handshakes; nothing is written or consumed that cycle.
    assign push    = q.in_valid && q.in_ready && !flush;
    assign pop     = q.out_valid && q.out_ready && !flush;
    assign wptr_d  = flush ? '0 : wptr_q + AW'(push);
    assign rptr_d  = flush ? '0 : rptr_q + AW'(pop);
    assign count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (push) mem_q[wptr_q] <= ent_d;
        end
    end

    assign q.in_ready    = count_q < CW'(DEPTH);
    assign q.out_valid   = count_q != '0;
    assign q.count       = count_q;
    assign q.out_pc      = mem_q[rptr_q].pc;
    assign q.out_type    = mem_q[rptr_q].typ;
    assign q.out_opcode  = mem_q[rptr_q].opc;
    assign q.out_funct3  = mem_q[rptr_q].f3;
    assign q.out_funct7  = mem_q[rptr_q].f7;
    assign q.out_rs1     = mem_q[rptr_q].rs1;
    assign q.out_rs2     = mem_q[rptr_q].rs2;
    assign q.out_rd      = mem_q[rptr_q].rd;
    assign q.out_imm     = mem_q[rptr_q].imm;
    assign q.out_illegal = mem_q[rptr_q].ill;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed checks of decode fields, FIFO ordering, full, flush and reset.
module tb_decode_queue;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;
    logic exp_m;

    decode_queue_if #(.DEPTH(4), .PC_W(32)) q ();
    decode_queue #(.DEPTH(4), .PC_W(32)) dut (.clk(clk), .rst(rst), .flush(flush), .q(q));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic [2:0] typ,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input logic ill);
        chk({tag, "_valid"}, 32'(q.out_valid), 32'd1);
        chk({tag, "_pc"}, q.out_pc, pc);
        chk({tag, "_type"}, 32'(q.out_type), 32'(typ));
        chk({tag, "_rs1"}, 32'(q.out_rs1), 32'(rs1));
        chk({tag, "_rs2"}, 32'(q.out_rs2), 32'(rs2));
        chk({tag, "_rd"}, 32'(q.out_rd), 32'(rd));
        chk({tag, "_f3"}, 32'(q.out_funct3), 32'(f3));
        chk({tag, "_f7"}, 32'(q.out_funct7), 32'(f7));
        chk({tag, "_imm"}, q.out_imm, imm);
        chk({tag, "_ill"}, 32'(q.out_illegal), 32'(ill));
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        q.in_valid = 1'b1;
        q.in_inst  = inst;
        q.in_pc    = pc;
        step();
        q.in_valid = 1'b0;
    endtask

    task automatic pop();
        q.out_ready = 1'b1;
        step();
        q.out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        q.in_valid = 1'b0;
        q.in_inst = '0;
        q.in_pc = '0;
        q.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_count", 32'(q.count), 32'd0);
        chk("rst_out_valid", 32'(q.out_valid), 32'd0);
        chk("rst_in_ready", 32'(q.in_ready), 32'd1);
        chk("rst_imm", q.out_imm, 32'd0);
        chk("rst_pc", q.out_pc, 32'd0);

        push(32'hFFF00093, 32'h100);
        head("addi", 32'h100, 3'd1, 5'd0, 5'd0, 5'd1, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0);
        chk("addi_opcode", 32'(q.out_opcode), 32'h13);
        pop();
        chk("addi_popped", 32'(q.count), 32'd0);

        push(32'h0020A423, 32'h104);
        push(32'hFE000EE3, 32'h108);
        push(32'h123452B7, 32'h10C);
        chk("three_count", 32'(q.count), 32'd3);
        head("sw", 32'h104, 3'd2, 5'd1, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8, 1'b0);
        pop();
        head("beq", 32'h108, 3'd3, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0);
        pop();
        head("lui", 32'h10C, 3'd5, 5'd0, 5'd0, 5'd5, 3'd0, 7'd0, 32'h12345000, 1'b0);
        pop();
        chk("empty_valid", 32'(q.out_valid), 32'd0);

        for (int i = 0; i < 5; i++) begin
            push(32'h00000013, 32'h200 + 32'(4 * i));
            chk($sformatf("fill_count%0d", i), 32'(q.count), (i < 4) ? 32'(i + 1) : 32'd4);
        end
        chk("full_in_ready", 32'(q.in_ready), 32'd0);
        q.out_ready = 1'b1;
        q.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q.in_pc = 32'h300 + 32'(4 * i);
            chk($sformatf("drain_pc%0d", i), q.out_pc, 32'h200 + 32'(4 * i));
            chk($sformatf("drain_ready%0d", i), 32'(q.in_ready), (i == 0) ? 32'd0 : 32'd1);
            step();
            chk($sformatf("drain_count%0d", i), 32'(q.count), 32'd3);
        end
        q.out_ready = 1'b0;
        chk("refill_head", q.out_pc, 32'h304);

        q.in_pc = 32'h400;
        flush = 1'b1;
        step();
        flush = 1'b0;
        q.in_valid = 1'b0;
        chk("flush_count", 32'(q.count), 32'd0);
        chk("flush_valid", 32'(q.out_valid), 32'd0);
        chk("flush_in_ready", 32'(q.in_ready), 32'd1);
        push(32'h00000013, 32'h500);
        chk("post_flush_count", 32'(q.count), 32'd1);
        chk("post_flush_pc", q.out_pc, 32'h500);
        pop();

`ifdef DECODE_RV32M_EN
        exp_m = 1'b0;
`else
        exp_m = 1'b1;
`endif
        push(32'h022081B3, 32'h600);
        head("mul", 32'h600, 3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'd1, 32'd0, exp_m);
        pop();
        push(32'h4010D093, 32'h604);
        head("srai", 32'h604, 3'd1, 5'd1, 5'd0, 5'd1, 3'd5, 7'h20, 32'h00000401, 1'b0);
        pop();
        push(32'h40109093, 32'h608);
        head("slli_bad", 32'h608, 3'd1, 5'd1, 5'd0, 5'd1, 3'd1, 7'h20, 32'h00000401, 1'b1);
        pop();
        push(32'h40001033, 32'h60C);
        head("sub_bad", 32'h60C, 3'd0, 5'd0, 5'd0, 5'd0, 3'd1, 7'h20, 32'd0, 1'b1);
        pop();
        push(32'h0080006F, 32'h610);
        head("jal", 32'h610, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b0);
        pop();

        push(32'h0000007F, 32'h700);
        push(32'hFFF00093, 32'h704);
        head("unknown", 32'h700, 3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1);
        chk("pre_rst_count", 32'(q.count), 32'd2);
        rst = 1'b1;
        flush = 1'b1;
        q.out_ready = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        q.out_ready = 1'b0;
        chk("rst2_count", 32'(q.count), 32'd0);
        chk("rst2_valid", 32'(q.out_valid), 32'd0);
        chk("rst2_in_ready", 32'(q.in_ready), 32'd1);
        chk("rst2_pc", q.out_pc, 32'd0);
        chk("rst2_ill", 32'(q.out_illegal), 32'd0);
        chk("rst2_imm", q.out_imm, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
